// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single 4-bit CLA,
// with a registered carry chaining the nibbles and valid/ready on both sides.

module CLA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is a flat sum of products of c0, so the slice is one lookahead deep
  assign c[0] = c0;
  assign c[1] = g[0] | (p[0] & c0);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c0);

  assign s  = p ^ c[3:0];
  assign c4 = c[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [IDX_W-1:0] idx;
  logic             cr;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_c4;
  logic             last_nib;

  CLA u_cla (
    .a  (nib_a),
    .b  (nib_b),
    .c0 (cr),
    .s  (nib_s),
    .c4 (nib_c4)
  );

  // Select the current operand nibbles and splice the CLA result into the accumulator
  always_comb begin
    nib_a    = '0;
    nib_b    = '0;
    acc_next = acc;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        nib_a                = a_reg[4*i +: 4];
        nib_b                = b_reg[4*i +: 4];
        acc_next[4*i +: 4]   = nib_s;
      end
    end
  end

  assign last_nib = (idx == IDX_W'(NIBBLES - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_nib) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, nibble sequencing and result registers; results only move entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      idx   <= '0;
      cr    <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= '0;
            cr    <= cin;
          end
        end
        RUN: begin
          acc <= acc_next;
          cr  <= nib_c4;
          idx <= idx + 1'b1;
          if (last_nib) begin
            sum  <= acc_next;
            cout <= nib_c4;
            ovf  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ nib_s[3] ^ nib_c4;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that feeds operands one nibble per cycle through a single instance of the team's 4-bit carry-lookahead adder (`CLA`: a, b, c0 -> s, c4). A registered carry links consecutive nibbles. The block sits directly upstream of the CLA slice and owns its operand sequencing, carry chaining and result assembly. It trades latency for area and uses a valid/ready handshake on both sides.

## Interface
- `WIDTH`, 16: operand and result width. It must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands present.
- `in_ready`  out  1: block can accept operands.
- `a`  in  WIDTH: addend A, unsigned or two's complement.
- `b`  in  WIDTH: addend B.
- `cin`  in  1: carry-in to nibble 0.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: consumer accepts the result.
- `sum`  out  WIDTH: a + b + cin, modulo 2^WIDTH.
- `cout`  out  1: carry out of the MSB.
- `ovf`  out  1: signed overflow.
- `busy`  out  1: the FSM is in RUN or DONE.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready`=1.
  - When `in_valid`&&`in_ready` at an edge, latch `a`, `b` and `cin`. Set nibble index idx=0 and carry register cr=`cin`. Go to RUN.
- **RUN:**
  - The CLA receives a[4*idx+:4], b[4*idx+:4] and c0=cr.
  - Each edge writes s into accumulator nibble idx, sets cr<=c4 and increments idx.
  - When idx==NIBBLES-1, go to DONE on that edge.
  - On the same edge, load the output registers:
    - `sum`<=full accumulator, including the final nibble.
    - `cout`<=c4.
    - `ovf`<=a[MSB]^b[MSB]^sum[MSB]^c4. The first three terms give the carry into the MSB; XOR with carry-out gives overflow.
- **DONE:**
  - `out_valid`=1.
  - When `out_ready`=1 at an edge, go to IDLE.
  - No new operand is accepted in DONE: `in_ready`=0.
- **Output stability:**
  - `sum`, `cout` and `ovf` change only on the edge entering DONE.
  - They hold their values through DONE and IDLE until the next result.
- **`in_valid` outside IDLE:** ignored in RUN and DONE. Latched operands are never overwritten mid-operation.
- **Arithmetic:**
  - Strictly modulo 2^WIDTH.
  - `cout` is the unsigned carry.
  - `ovf` is meaningful only for two's-complement operands.
- **Reset (`rst_n`=0, asynchronous):**
  - state=IDLE, idx=0, cr=0, accumulator=0.
  - `sum`=0, `cout`=0, `ovf`=0, `out_valid`=0, `busy`=0.
  - `in_ready` is decoded from state, so it reads 1 while in reset.
  - Reset asserted during RUN or DONE aborts the operation with no result emitted.
- **WIDTH=4:** RUN lasts exactly one cycle.

## Timing
- Acceptance edge E0. RUN occupies the cycles ending at edges E1..E_NIBBLES.
- `out_valid` rises after edge E_NIBBLES. For WIDTH=16 that is E4.
- If `out_ready` is already 1, `out_valid` is high for exactly one cycle. `in_ready` returns high after E_NIBBLES+1.
- Maximum throughput is one operation per NIBBLES+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid`, `out_ready`, `a` or `b` to any output.
- Critical path: cr -> CLA -> cr. This is one 4-bit lookahead per cycle.

## Test plan
All scenarios use WIDTH=16.
- Accept a=0x1234, b=0x4321, cin=0 -> `out_valid` exactly 4 edges after acceptance; `sum`=0x5555, `cout`=0, `ovf`=0.
- a=0xFFFF, b=0x0001, cin=0 (carry propagates through all four nibbles) -> `sum`=0x0000, `cout`=1, `ovf`=0.
- a=0x7FFF, b=0x0001, cin=0 -> `sum`=0x8000, `cout`=0, `ovf`=1. Then a=0x8000, b=0x8000 -> `sum`=0x0000, `cout`=1, `ovf`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`, and toggle `in_valid` with new operands -> `sum`, `cout` and `ovf` are stable, `in_ready`=0, new operands are ignored. After `out_ready`=1, IDLE follows on the next edge.
- Deassert `rst_n` mid-RUN (after E2) with no clock edge pending -> all outputs are immediately 0 and `in_ready`=1. A following operation a=0xABCD, b=0x1234, cin=1 yields `sum`=0xBE02, `cout`=0, `ovf`=0.
- Back-to-back operations with `in_valid` and `out_ready` held high -> accepts are spaced exactly 6 cycles apart. Every result matches the reference model a+b+cin, checked over at least 1000 random vectors including cin.
